// File: rtl/io_cpx_outq.sv
// io_cpx_outq: outbound IO-to-CPX packet queue with per-destination credits.
// Buffers IO-bridge return packets in an in-order FIFO and issues each one as
// a one-cycle request mask on io_cpx_req_cq. The matching data beat follows on
// io_cpx_data_ca exactly one cycle later. A packet issues only when every
// destination it targets has fewer than MAX_OUT ungranted packets.
//
// Ports:
//   rclk, arst_l       clock and asynchronous active-low reset
//   enq_vld/dest/data  packet offer; accepted when enq_rdy is high
//   enq_rdy            queue not full
//   io_cpx_req_cq      registered request mask to the CPX
//   io_cpx_data_ca     registered data beat, one cycle after its request
//   cpx_io_grant_cx    per-destination grant pulses; each returns one credit
//   q_empty            FIFO holds no entries
//   grant_err          sticky: grant arrived on a destination with nothing outstanding
module io_cpx_outq #(
  parameter int unsigned WIDTH   = 145,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic             rclk,
  input  logic             arst_l,
  input  logic             enq_vld,
  input  logic [7:0]       enq_dest,
  input  logic [WIDTH-1:0] enq_data,
  output logic             enq_rdy,
  output logic [7:0]       io_cpx_req_cq,
  output logic [WIDTH-1:0] io_cpx_data_ca,
  input  logic [7:0]       cpx_io_grant_cx,
  output logic             q_empty,
  output logic             grant_err
);

  localparam int unsigned NDEST = 8;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned CNT_W = 2;

  // FIFO storage (payload is not reset; validity comes from the pointers)
  logic [NDEST-1:0] dest_mem [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [CNT_W-1:0] cnt_q [NDEST];
  logic [CNT_W-1:0] cnt_d [NDEST];
  logic [NDEST-1:0] req_q, req_d;
  logic [WIDTH-1:0] stage_q, stage_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             issued_q, issued_d;
  logic             grant_err_q, grant_err_d;

  logic             enq_fire;
  logic             credit_ok;
  logic             issue;
  logic [NDEST-1:0] head_dest;
  logic [NDEST-1:0] issue_vec;
  logic [WIDTH-1:0] head_data;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];

  // Payload write port
  always_ff @(posedge rclk) begin
    if (enq_fire) begin
      dest_mem[wr_idx] <= enq_dest;
      data_mem[wr_idx] <= enq_data;
    end
  end

  // Issue decision, pointer update, credit accounting and output pipeline
  always_comb begin
    // A zero destination mask is dropped without touching the FIFO.
    enq_fire  = enq_vld & ~full_q & (|enq_dest);
    head_dest = dest_mem[rd_idx];
    head_data = data_mem[rd_idx];

    // Gate on registered counts only; same-cycle grants do not help.
    credit_ok = 1'b1;
    for (int i = 0; i < NDEST; i++) begin
      if (head_dest[i] && (cnt_q[i] >= CNT_W'(MAX_OUT))) begin
        credit_ok = 1'b0;
      end
    end
    issue     = ~empty_q & credit_ok;
    issue_vec = issue ? head_dest : '0;

    wr_ptr_d = wr_ptr_q + PW'(enq_fire);
    rd_ptr_d = rd_ptr_q + PW'(issue);
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

    // Issue and grant on the same bit cancel; a grant on an idle bit is an error.
    grant_err_d = grant_err_q;
    for (int i = 0; i < NDEST; i++) begin
      cnt_d[i] = cnt_q[i];
      if (issue_vec[i] && !cpx_io_grant_cx[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (!issue_vec[i] && cpx_io_grant_cx[i]) begin
        if (cnt_q[i] == '0) begin
          grant_err_d = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end
    end

    // Request goes out the cycle after issue; data one cycle after that.
    req_d    = issue_vec;
    issued_d = issue;
    stage_d  = issue ? head_data : stage_q;
    data_d   = issued_q ? stage_q : '0;
  end

  // State registers
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      req_q       <= '0;
      stage_q     <= '0;
      data_q      <= '0;
      issued_q    <= 1'b0;
      grant_err_q <= 1'b0;
      for (int i = 0; i < NDEST; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      req_q       <= req_d;
      stage_q     <= stage_d;
      data_q      <= data_d;
      issued_q    <= issued_d;
      grant_err_q <= grant_err_d;
      for (int i = 0; i < NDEST; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign enq_rdy        = ~full_q;
  assign q_empty        = empty_q;
  assign io_cpx_req_cq  = req_q;
  assign io_cpx_data_ca = data_q;
  assign grant_err      = grant_err_q;

endmodule
